// File: rtl/dbg_ctrl_pkg.sv
// Shared defines for the debug controller: bus widths, access-size type, FSM encoding
// and the default drain/reset lengths.
package dbg_ctrl_pkg;

  localparam int unsigned RegBus = 32;

  typedef logic [1:0] mem_type_bus;

  localparam int unsigned DrainCyclesDef = 4;
  localparam int unsigned ResetCyclesDef = 8;

  localparam logic [2:0] StRun    = 3'd0;
  localparam logic [2:0] StDrain  = 3'd1;
  localparam logic [2:0] StHalted = 3'd2;
  localparam logic [2:0] StAccess = 3'd3;
  localparam logic [2:0] StReset  = 3'd4;

  typedef enum logic [1:0] {MuxCore, MuxDbg, MuxIdle} mux_sel_e;

  // Counter width for a cycle count; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/dbg_ctrl_if.sv
// Debug memory-access channel: request from the debugger, grant/response from dbg_ctrl.
interface dbg_ctrl_if;
  import dbg_ctrl_pkg::*;

  logic                dbg_mem_req;
  logic                dbg_mem_we;
  logic [RegBus-1:0]   dbg_mem_addr;
  logic [RegBus-1:0]   dbg_mem_wdata;
  mem_type_bus         dbg_mem_type;
  logic                dbg_mem_gnt;
  logic                dbg_mem_rvalid;
  logic [RegBus-1:0]   dbg_mem_rdata;

  modport master (
    output dbg_mem_req, dbg_mem_we, dbg_mem_addr, dbg_mem_wdata, dbg_mem_type,
    input  dbg_mem_gnt, dbg_mem_rvalid, dbg_mem_rdata
  );

  modport slave (
    input  dbg_mem_req, dbg_mem_we, dbg_mem_addr, dbg_mem_wdata, dbg_mem_type,
    output dbg_mem_gnt, dbg_mem_rvalid, dbg_mem_rdata
  );

endinterface

// File: rtl/dbg_mem_mux.sv
// Memory-port selector: core pass-through, registered debug access, or idle.
module dbg_mem_mux
  import dbg_ctrl_pkg::*;
(
  input  mux_sel_e            sel,
  input  logic [RegBus-1:0]   core_mem_addr,
  input  logic [RegBus-1:0]   core_mem_wdata,
  input  mem_type_bus         core_mem_type,
  input  logic                core_mem_sign,
  input  logic                core_rmem,
  input  logic                core_wmem,
  output logic [RegBus-1:0]   core_mem_rdata,
  input  logic [RegBus-1:0]   dbg_addr,
  input  logic [RegBus-1:0]   dbg_wdata,
  input  mem_type_bus         dbg_type,
  input  logic                dbg_we,
  output logic [RegBus-1:0]   mem_addr,
  output logic [RegBus-1:0]   mem_wdata,
  output mem_type_bus         mem_type,
  output logic                mem_sign,
  output logic                rmem,
  output logic                wmem,
  input  logic [RegBus-1:0]   mem_rdata
);

  always_comb begin
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_type       = '0;
    mem_sign       = 1'b0;
    rmem           = 1'b0;
    wmem           = 1'b0;
    core_mem_rdata = '0;
    unique case (sel)
      MuxCore: begin
        mem_addr       = core_mem_addr;
        mem_wdata      = core_mem_wdata;
        mem_type       = core_mem_type;
        mem_sign       = core_mem_sign;
        rmem           = core_rmem;
        wmem           = core_wmem;
        core_mem_rdata = mem_rdata;
      end
      MuxDbg: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_type  = dbg_type;
        rmem      = ~dbg_we;
        wmem      = dbg_we;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dbg_ctrl.sv
// Debug controller: halts the core, drains its pipeline, then lends the memory port to the
// debugger for single-cycle accesses; also issues a timed core reset.
module dbg_ctrl
  import dbg_ctrl_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DrainCyclesDef,
  parameter int unsigned RESET_CYCLES = ResetCyclesDef
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dbg_halt_req,
  input  logic                dbg_resume_req,
  input  logic                dbg_reset_req,
  dbg_ctrl_if.slave           dbg_mem,
  input  logic [RegBus-1:0]   core_mem_addr,
  input  logic [RegBus-1:0]   core_mem_wdata,
  input  mem_type_bus         core_mem_type,
  input  logic                core_mem_sign,
  input  logic                core_rmem,
  input  logic                core_wmem,
  output logic [RegBus-1:0]   core_mem_rdata,
  output logic [RegBus-1:0]   mem_addr,
  output logic [RegBus-1:0]   mem_wdata,
  output mem_type_bus         mem_type,
  output logic                mem_sign,
  output logic                rmem,
  output logic                wmem,
  input  logic [RegBus-1:0]   mem_rdata,
  output logic                halt_req_o,
  output logic                reset_req_o,
  output logic                halted
);

  localparam int unsigned DrainCw = cnt_width(DRAIN_CYCLES);
  localparam int unsigned ResetCw = cnt_width(RESET_CYCLES);
  localparam logic [DrainCw-1:0] DrainLoad = DrainCw'(DRAIN_CYCLES - 1);
  localparam logic [ResetCw-1:0] ResetLoad = ResetCw'(RESET_CYCLES - 1);

  logic [2:0]          state_q, state_d;
  logic [DrainCw-1:0]  drain_cnt_q, drain_cnt_d;
  logic [ResetCw-1:0]  reset_cnt_q, reset_cnt_d;
  logic                req_we_q;
  logic [RegBus-1:0]   req_addr_q, req_wdata_q;
  mem_type_bus         req_type_q;
  logic                rvalid_q, rvalid_d;
  logic [RegBus-1:0]   rdata_q;
  logic                accept;
  mux_sel_e            mux_sel;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    reset_cnt_d = reset_cnt_q;
    accept      = 1'b0;
    if (dbg_reset_req) begin
      state_d     = StReset;
      reset_cnt_d = ResetLoad;
    end else begin
      case (state_q)
        StRun: begin
          if (dbg_halt_req) begin
            state_d     = StDrain;
            drain_cnt_d = DrainLoad;
          end
        end
        StDrain: begin
          // Counter parks at zero until the core stops touching memory.
          if (!dbg_halt_req) begin
            state_d = StRun;
          end else if (drain_cnt_q == '0) begin
            if (!core_rmem && !core_wmem) state_d = StHalted;
          end else begin
            drain_cnt_d = drain_cnt_q - 1'b1;
          end
        end
        StHalted: begin
          if (dbg_mem.dbg_mem_req) begin
            accept  = 1'b1;
            state_d = StAccess;
          end else if (dbg_resume_req) begin
            state_d = StRun;
          end
        end
        StAccess: state_d = StHalted;
        StReset: begin
          if (reset_cnt_q == '0) begin
            state_d = dbg_halt_req ? StHalted : StRun;
          end else begin
            reset_cnt_d = reset_cnt_q - 1'b1;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  // A reset request cancels the response of an in-flight read.
  assign rvalid_d = (state_q == StAccess) && !req_we_q && !dbg_reset_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      drain_cnt_q <= '0;
      reset_cnt_q <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_type_q  <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      reset_cnt_q <= reset_cnt_d;
      rvalid_q    <= rvalid_d;
      if (accept) begin
        req_we_q    <= dbg_mem.dbg_mem_we;
        req_addr_q  <= dbg_mem.dbg_mem_addr;
        req_wdata_q <= dbg_mem.dbg_mem_wdata;
        req_type_q  <= dbg_mem.dbg_mem_type;
      end
      if (rvalid_d) rdata_q <= mem_rdata;
    end
  end

  // Memory goes idle under rst so an abandoned access never writes.
  always_comb begin
    mux_sel = MuxIdle;
    if (!rst) begin
      case (state_q)
        StRun, StDrain: mux_sel = MuxCore;
        StAccess:       mux_sel = MuxDbg;
        default:        mux_sel = MuxIdle;
      endcase
    end
  end

  dbg_mem_mux u_mem_mux (
    .sel            (mux_sel),
    .core_mem_addr  (core_mem_addr),
    .core_mem_wdata (core_mem_wdata),
    .core_mem_type  (core_mem_type),
    .core_mem_sign  (core_mem_sign),
    .core_rmem      (core_rmem),
    .core_wmem      (core_wmem),
    .core_mem_rdata (core_mem_rdata),
    .dbg_addr       (req_addr_q),
    .dbg_wdata      (req_wdata_q),
    .dbg_type       (req_type_q),
    .dbg_we         (req_we_q),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_type       (mem_type),
    .mem_sign       (mem_sign),
    .rmem           (rmem),
    .wmem           (wmem),
    .mem_rdata      (mem_rdata)
  );

  assign halt_req_o             = (state_q != StRun);
  assign reset_req_o            = (state_q == StReset);
  assign halted                 = (state_q == StHalted) || (state_q == StAccess);
  assign dbg_mem.dbg_mem_gnt    = accept && !rst;
  assign dbg_mem.dbg_mem_rvalid = rvalid_q;
  assign dbg_mem.dbg_mem_rdata  = rdata_q;

endmodule

// File: tb/tb_dbg_ctrl.sv
// Directed bench for dbg_ctrl with a small word-addressed memory model on the memory port.
module tb_dbg_ctrl;
  import dbg_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              dbg_halt_req, dbg_resume_req, dbg_reset_req;
  logic [31:0]       core_mem_addr, core_mem_wdata, core_mem_rdata;
  mem_type_bus       core_mem_type;
  logic              core_mem_sign, core_rmem, core_wmem;
  logic [31:0]       mem_addr, mem_wdata, mem_rdata;
  mem_type_bus       mem_type;
  logic              mem_sign, rmem, wmem;
  logic              halt_req_o, reset_req_o, halted;
  logic [31:0]       mem_arr [256];
  int                errors = 0;
  int                checks = 0;
  int                n_rst;
  logic              seen_rv;

  dbg_ctrl_if dbg_bus ();

  dbg_ctrl #(
    .DRAIN_CYCLES (4),
    .RESET_CYCLES (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .dbg_halt_req   (dbg_halt_req),
    .dbg_resume_req (dbg_resume_req),
    .dbg_reset_req  (dbg_reset_req),
    .dbg_mem        (dbg_bus),
    .core_mem_addr  (core_mem_addr),
    .core_mem_wdata (core_mem_wdata),
    .core_mem_type  (core_mem_type),
    .core_mem_sign  (core_mem_sign),
    .core_rmem      (core_rmem),
    .core_wmem      (core_wmem),
    .core_mem_rdata (core_mem_rdata),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_type       (mem_type),
    .mem_sign       (mem_sign),
    .rmem           (rmem),
    .wmem           (wmem),
    .mem_rdata      (mem_rdata),
    .halt_req_o     (halt_req_o),
    .reset_req_o    (reset_req_o),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= '0;
    end else if (wmem) begin
      mem_arr[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_arr[mem_addr[9:2]];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse already issued; count reset_req_o cycles and watch for stray rvalid.
  task automatic watch_reset();
    n_rst   = 0;
    seen_rv = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (reset_req_o) n_rst++;
      if (dbg_bus.dbg_mem_rvalid) seen_rv = 1'b1;
      tick();
    end
  endtask

  task automatic halt_clean(input string tag);
    dbg_halt_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq(tag, halted, (i == 5));
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    {dbg_halt_req, dbg_resume_req, dbg_reset_req} = '0;
    {core_mem_sign, core_rmem, core_wmem} = '0;
    core_mem_addr = '0; core_mem_wdata = '0; core_mem_type = 2'b10;
    dbg_bus.dbg_mem_req = 1'b0; dbg_bus.dbg_mem_we = 1'b0;
    dbg_bus.dbg_mem_addr = '0; dbg_bus.dbg_mem_wdata = '0; dbg_bus.dbg_mem_type = 2'b10;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("rst_halt_req", halt_req_o, 0);
    check_eq("rst_reset_req", reset_req_o, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_gnt", dbg_bus.dbg_mem_gnt, 0);
    check_eq("rst_rvalid", dbg_bus.dbg_mem_rvalid, 0);
    check_eq("rst_rdata", dbg_bus.dbg_mem_rdata, 0);

    // RUN pass-through
    core_wmem = 1'b1; core_mem_addr = 32'h20; core_mem_wdata = 32'hA5A5_0001;
    #1;
    check_eq("run_wmem", wmem, 1);
    check_eq("run_addr", mem_addr, 32'h20);
    tick();
    core_wmem = 1'b0; core_rmem = 1'b1;
    #1;
    check_eq("run_rmem", rmem, 1);
    check_eq("run_rdata", core_mem_rdata, 32'hA5A5_0001);
    core_rmem = 1'b0;

    // Halt during a six-store stream: drain holds until the stream ends
    for (int i = 0; i < 8; i++) begin
      dbg_halt_req   = 1'b1;
      core_wmem      = (i < 6);
      core_mem_addr  = 32'h40 + 4 * i;
      core_mem_wdata = 32'h1000 + i;
      #1;
      check_eq("stream_halted", halted, (i == 7));
      check_eq("stream_halt_req", halt_req_o, (i != 0));
      tick();
    end
    core_wmem = 1'b0;
    for (int j = 0; j < 6; j++) check_eq("stream_store", mem_arr[16 + j], 32'h1000 + j);

    // Core stores and loads are blocked while halted
    core_wmem = 1'b1; core_rmem = 1'b1; core_mem_addr = 32'h80; core_mem_wdata = 32'hBAD0_0000;
    #1;
    check_eq("blk_wmem", wmem, 0);
    check_eq("blk_rmem", rmem, 0);
    check_eq("blk_rdata", core_mem_rdata, 0);
    tick();
    core_wmem = 1'b0; core_rmem = 1'b0;
    check_eq("blk_mem", mem_arr[32], 0);

    // Debug write then read of 0x100
    dbg_bus.dbg_mem_req = 1'b1; dbg_bus.dbg_mem_we = 1'b1;
    dbg_bus.dbg_mem_addr = 32'h100; dbg_bus.dbg_mem_wdata = 32'hDEAD_BEEF;
    #1;
    check_eq("wr_gnt", dbg_bus.dbg_mem_gnt, 1);
    tick();
    dbg_bus.dbg_mem_req = 1'b0;
    check_eq("wr_wmem", wmem, 1);
    check_eq("wr_addr", mem_addr, 32'h100);
    check_eq("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    check_eq("wr_halted", halted, 1);
    tick();
    check_eq("wr_wmem_end", wmem, 0);
    check_eq("wr_no_rvalid", dbg_bus.dbg_mem_rvalid, 0);
    dbg_bus.dbg_mem_req = 1'b1; dbg_bus.dbg_mem_we = 1'b0;
    #1;
    check_eq("rd_gnt", dbg_bus.dbg_mem_gnt, 1);
    tick();
    dbg_bus.dbg_mem_req = 1'b0;
    check_eq("rd_rmem", rmem, 1);
    check_eq("rd_rvalid_early", dbg_bus.dbg_mem_rvalid, 0);
    tick();
    check_eq("rd_rvalid", dbg_bus.dbg_mem_rvalid, 1);
    check_eq("rd_rdata", dbg_bus.dbg_mem_rdata, 32'hDEAD_BEEF);
    tick();
    check_eq("rd_rvalid_end", dbg_bus.dbg_mem_rvalid, 0);
    check_eq("rd_rdata_hold", dbg_bus.dbg_mem_rdata, 32'hDEAD_BEEF);

    // Simultaneous request and resume: request wins, resume dropped
    dbg_bus.dbg_mem_req = 1'b1; dbg_resume_req = 1'b1;
    #1;
    check_eq("pri_gnt", dbg_bus.dbg_mem_gnt, 1);
    tick();
    dbg_bus.dbg_mem_req = 1'b0; dbg_resume_req = 1'b0;
    check_eq("pri_access", halted, 1);
    tick();
    check_eq("pri_halted", halted, 1);
    tick();
    check_eq("pri_no_run", halt_req_o, 1);

    // Core reset during a read access, halt still requested
    dbg_bus.dbg_mem_req = 1'b1;
    tick();
    dbg_bus.dbg_mem_req = 1'b0; dbg_reset_req = 1'b1;
    tick();
    dbg_reset_req = 1'b0;
    watch_reset();
    check_eq("rstacc_len", n_rst, 8);
    check_eq("rstacc_rvalid", seen_rv, 0);
    check_eq("rstacc_halted", halted, 1);

    // Core reset with halt released ends in RUN
    dbg_halt_req = 1'b0; dbg_reset_req = 1'b1;
    tick();
    dbg_reset_req = 1'b0;
    watch_reset();
    check_eq("rstrun_len", n_rst, 8);
    check_eq("rstrun_halt_req", halt_req_o, 0);
    check_eq("rstrun_halted", halted, 0);

    // Halt dropped in the second drain cycle
    dbg_halt_req = 1'b1;
    #1;
    check_eq("abort_run", halt_req_o, 0);
    tick();
    check_eq("abort_drain1", halt_req_o, 1);
    tick();
    check_eq("abort_drain2", halt_req_o, 1);
    dbg_halt_req = 1'b0;
    tick();
    check_eq("abort_back", halt_req_o, 0);
    check_eq("abort_halted", halted, 0);
    tick();
    check_eq("abort_stay", halted, 0);

    // rst during a debug write access: no memory write
    halt_clean("drain4_a");
    dbg_bus.dbg_mem_req = 1'b1; dbg_bus.dbg_mem_we = 1'b1;
    dbg_bus.dbg_mem_addr = 32'h200; dbg_bus.dbg_mem_wdata = 32'h1234_5678;
    #1;
    check_eq("rsta_gnt", dbg_bus.dbg_mem_gnt, 1);
    tick();
    dbg_bus.dbg_mem_req = 1'b0; rst = 1'b1;
    #1;
    check_eq("rsta_wmem", wmem, 0);
    tick();
    rst = 1'b0; dbg_halt_req = 1'b0;
    #1;
    check_eq("rsta_halted", halted, 0);
    check_eq("rsta_halt_req", halt_req_o, 0);
    check_eq("rsta_mem", mem_arr[128], 0);

    // rst together with a request in HALTED: no grant
    halt_clean("drain4_b");
    dbg_bus.dbg_mem_req = 1'b1; rst = 1'b1;
    #1;
    check_eq("rsth_gnt", dbg_bus.dbg_mem_gnt, 0);
    tick();
    rst = 1'b0; dbg_bus.dbg_mem_req = 1'b0; dbg_halt_req = 1'b0;
    #1;
    check_eq("rsth_halted", halted, 0);
    check_eq("rsth_rvalid", dbg_bus.dbg_mem_rvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dbg_ctrl.md
DBG_CTRL -- requirements
Module: dbg_ctrl

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 4, giving the cycles the core pipeline is held in halt before memory is handed to debug.
REQ-002 The block SHALL have parameter RESET_CYCLES, default 8, giving the length of the core reset pulse.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high: clk  in  1  core clock; rst  in  1  synchronous active-high reset.
REQ-004 The debug request ports SHALL be: dbg_halt_req  in  1  level halt request; dbg_resume_req  in  1  single-cycle resume pulse; dbg_reset_req  in  1  single-cycle core-reset pulse.
REQ-005 The debug memory request ports SHALL be: dbg_mem_req  in  1  access request; dbg_mem_we  in  1  1=write; dbg_mem_addr  in  32; dbg_mem_wdata  in  32; dbg_mem_type  in  mem_type_bus  access size.
REQ-006 The debug memory response ports SHALL be: dbg_mem_gnt  out  1  request accepted; dbg_mem_rvalid  out  1  read data valid; dbg_mem_rdata  out  32.
REQ-007 The core-side ports SHALL be: core_mem_addr/core_mem_wdata  in  32; core_mem_type  in  mem_type_bus; core_mem_sign, core_rmem, core_wmem  in  1; core_mem_rdata  out  32.
REQ-008 The memory-side ports SHALL be: mem_addr/mem_wdata  out  32; mem_type  out  mem_type_bus; mem_sign, rmem, wmem  out  1; mem_rdata  in  32 (combinational read).
REQ-009 The core-control ports SHALL be: halt_req_o  out  1  freezes PC/IF-ID/ID-EX; reset_req_o  out  1  core reset; halted  out  1  debug owns memory.

Function
REQ-010 The FSM SHALL have exactly the states RUN, DRAIN, HALTED, ACCESS and RESET.
REQ-011 In RUN: halt_req_o=0, the memory port passes core signals through, and core_mem_rdata=mem_rdata combinationally.
REQ-012 From RUN, dbg_halt_req=1 SHALL move to DRAIN and load the drain counter with DRAIN_CYCLES-1.
REQ-013 In DRAIN: halt_req_o=1 and core pass-through is kept; the counter decrements each cycle; the FSM leaves for HALTED only when counter==0 and core_rmem=core_wmem=0, and otherwise holds at 0.
REQ-014 In DRAIN, if dbg_halt_req falls before HALTED is reached, the FSM SHALL return to RUN the next cycle.
REQ-015 In HALTED and ACCESS: halted=1 and halt_req_o=1; core_rmem and core_wmem SHALL be blocked (never reach memory); core_mem_rdata=0.
REQ-016 In HALTED, dbg_mem_req=1 SHALL pulse dbg_mem_gnt for that cycle, register addr/wdata/type/we, and move to ACCESS.
REQ-017 In HALTED, dbg_resume_req=1 with dbg_mem_req=0 SHALL move to RUN; dbg_mem_req has priority over a simultaneous resume, and that resume is dropped.
REQ-018 ACCESS SHALL last exactly one cycle: memory is driven from the registered request (rmem=~we, wmem=we, mem_sign=0), mem_rdata is captured on a read, and the FSM returns to HALTED.
REQ-019 After a read ACCESS, dbg_mem_rvalid SHALL pulse for one cycle with dbg_mem_rdata valid (read latency of 2 cycles from gnt); writes produce no rvalid; dbg_mem_rdata holds until the next read.
REQ-020 dbg_reset_req SHALL move any state to RESET with the highest priority and load the reset counter with RESET_CYCLES-1; an ACCESS in progress completes its memory cycle but gives no rvalid.
REQ-021 In RESET: reset_req_o=1, halt_req_o=1, and memory outputs are idle (rmem=wmem=0); at count 0 the FSM moves to HALTED if dbg_halt_req=1, else to RUN.
REQ-022 Both counters SHALL be $clog2(max(param,2)) bits wide, SHALL not wrap, and SHALL saturate at 0.

Reset
REQ-023 On rst the FSM SHALL be in RUN, both counters 0, halt_req_o=reset_req_o=halted=0, dbg_mem_gnt=dbg_mem_rvalid=0, dbg_mem_rdata=0, and the captured request registers 0.
REQ-024 Asserting rst in any state SHALL abandon that state at the next edge without issuing gnt, rvalid or a memory write.

Structure
REQ-025 The FSM state encoding and the default values of DRAIN_CYCLES and RESET_CYCLES SHALL live in the shared defines file next to mem_type_bus and RegBus.
REQ-026 The memory-port multiplexer SHALL be one purely combinational sub-module, dbg_mem_mux (select core, debug or idle); the FSM and counters stay in dbg_ctrl.

Verification
REQ-027 Verification SHALL cover: halt asserted during a core store stream -> halted=1 only after 4 cycles and after the last core_wmem, with no core write lost.
REQ-028 Verification SHALL cover: HALTED, write 0xDEADBEEF to 0x100, then read 0x100 -> a wmem pulse of 1 cycle, then dbg_mem_rvalid exactly 2 cycles after the read gnt with rdata=0xDEADBEEF.
REQ-029 Verification SHALL cover: HALTED with dbg_mem_req and dbg_resume_req in the same cycle -> ACCESS is taken, the FSM returns to HALTED, and does not reach RUN.
REQ-030 Verification SHALL cover: dbg_reset_req during ACCESS -> reset_req_o high for exactly 8 cycles, no rvalid, then RUN (halt_req low) or HALTED (halt_req high).
REQ-031 Verification SHALL cover: halt_req dropped in the 2nd DRAIN cycle -> RUN next cycle and halted never set.
REQ-032 Verification SHALL cover: core_wmem asserted while HALTED -> wmem stays 0.
